// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: shared widths, op bit indices, FSM states and helpers for the M-extension sequencer.
package mdu_seq_pkg;
  localparam int XLEN = 64;
  localparam int MDU_INFO_WIDTH = 13;
  localparam int MDU_MUL = 0;
  localparam int MDU_MULH = 1;
  localparam int MDU_MULHSU = 2;
  localparam int MDU_MULHU = 3;
  localparam int MDU_DIV = 4;
  localparam int MDU_DIVU = 5;
  localparam int MDU_REM = 6;
  localparam int MDU_REMU = 7;
  localparam int MDU_MULW = 8;
  localparam int MDU_DIVW = 9;
  localparam int MDU_DIVUW = 10;
  localparam int MDU_REMW = 11;
  localparam int MDU_REMUW = 12;
  localparam int MDU_ITER64 = 64;
  localparam int MDU_ITER32 = 32;
  typedef enum logic [1:0] {MDU_IDLE, MDU_CALC, MDU_DONE} mdu_state_e;
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return {{(XLEN-32){x[31]}}, x};
  endfunction
endpackage

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response handshake and status bundle between the core and the sequencer.
interface mdu_seq_if import mdu_seq_pkg::*; ();
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [MDU_INFO_WIDTH-1:0] mdu_info_i;
  logic [XLEN-1:0]           rs1_rdata_i;
  logic [XLEN-1:0]           rs2_rdata_i;
  logic                      flush_i;
  logic                      resp_valid_o;
  logic                      resp_ready_i;
  logic [XLEN-1:0]           mdu_res_o;
  logic                      busy_o;
  modport slave (
    input  req_valid_i, mdu_info_i, rs1_rdata_i, rs2_rdata_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, mdu_res_o, busy_o
  );
  modport master (
    output req_valid_i, mdu_info_i, rs1_rdata_i, rs2_rdata_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, mdu_res_o, busy_o
  );
endinterface

// File: rtl/mdu_seq_iter.sv
// mdu_seq_iter: one radix-2 step; add-shift for multiply, compare-subtract-shift for restoring divide.
module mdu_seq_iter import mdu_seq_pkg::*; (
  input  logic              is_mul_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic [2*XLEN-1:0] acc_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic          ge;
  // acc high half is the partial product / remainder, low half the multiplier / dividend-quotient
  always_comb begin
    sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    trial = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    ge = trial >= {1'b0, opb_i};
    acc_o = is_mul_i ? {sum, acc_i[XLEN-1:1]}
                     : {ge ? trial[XLEN-1:0] - opb_i : trial[XLEN-1:0], acc_i[XLEN-2:0], ge};
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV64M multiply/divide sequencer with operand conditioning, special cases and sign fix-up.
module mdu_seq import mdu_seq_pkg::*; (
  input logic       clk_i,
  input logic       rst_i,
  mdu_seq_if.slave  bus
);
  mdu_state_e                state_q, state_d;
  logic [5:0]                cnt_q;
  logic [2*XLEN-1:0]         acc_q, acc_n, p;
  logic [XLEN-1:0]           opb_q, res_q;
  logic                      is_w_q, is_mul_q, is_mulh_q, is_rem_q, negp_q, sign1_q;
  logic [MDU_INFO_WIDTH-1:0] op;
  logic                      is_w, is_mul, is_mulh, is_rem, s1, s2, sign1, sign2;
  logic                      div0, ovf, special, accept;
  logic [XLEN-1:0]           a, b, mag1, mag2, sres, spec_res, q, r, mres, fin, fin_res;
  assign op = bus.mdu_info_i;
  assign accept = state_q == MDU_IDLE && bus.req_valid_i && !bus.flush_i;
  always_comb begin
    is_w = op[MDU_MULW] | op[MDU_DIVW] | op[MDU_DIVUW] | op[MDU_REMW] | op[MDU_REMUW];
    is_mul = op[MDU_MUL] | op[MDU_MULH] | op[MDU_MULHSU] | op[MDU_MULHU] | op[MDU_MULW];
    is_mulh = op[MDU_MULH] | op[MDU_MULHSU] | op[MDU_MULHU];
    is_rem = op[MDU_REM] | op[MDU_REMU] | op[MDU_REMW] | op[MDU_REMUW];
    s2 = op[MDU_MULH] | op[MDU_DIV] | op[MDU_REM] | op[MDU_DIVW] | op[MDU_REMW];
    s1 = s2 | op[MDU_MULHSU];
    a = is_w ? (s1 ? sext32(bus.rs1_rdata_i[31:0]) : {32'b0, bus.rs1_rdata_i[31:0]}) : bus.rs1_rdata_i;
    b = is_w ? (s2 ? sext32(bus.rs2_rdata_i[31:0]) : {32'b0, bus.rs2_rdata_i[31:0]}) : bus.rs2_rdata_i;
    sign1 = s1 & a[XLEN-1];
    sign2 = s2 & b[XLEN-1];
    mag1 = sign1 ? -a : a;
    mag2 = sign2 ? -b : b;
    div0 = !is_mul && b == '0;
    ovf = !is_mul && s2 && &b && a == (is_w ? {{33{1'b1}}, 31'b0} : {1'b1, 63'b0});
    special = div0 | ovf;
    sres = div0 ? (is_rem ? a : '1) : (is_rem ? '0 : a);
    spec_res = is_w ? sext32(sres[31:0]) : sres;
  end
  mdu_seq_iter u_iter (.is_mul_i(is_mul_q), .acc_i(acc_q), .opb_i(opb_q), .acc_o(acc_n));
  // W multiplies finish after 32 shifts, leaving the product sitting 32 bits up in acc
  always_comb begin
    p = negp_q ? -acc_n : acc_n;
    q = negp_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    r = sign1_q ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    mres = is_mulh_q ? p[2*XLEN-1:XLEN] : is_w_q ? {32'b0, p[63:32]} : p[XLEN-1:0];
    fin = is_mul_q ? mres : is_rem_q ? r : q;
    fin_res = is_w_q ? sext32(fin[31:0]) : fin;
  end
  always_comb begin
    state_d = bus.flush_i ? MDU_IDLE
            : state_q == MDU_IDLE ? (bus.req_valid_i ? (special ? MDU_DONE : MDU_CALC) : MDU_IDLE)
            : state_q == MDU_CALC ? (cnt_q == '0 ? MDU_DONE : MDU_CALC)
            : (bus.resp_ready_i ? MDU_IDLE : MDU_DONE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      {is_w_q, is_mul_q, is_mulh_q, is_rem_q, negp_q, sign1_q} <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        {is_w_q, is_mul_q, is_mulh_q, is_rem_q} <= {is_w, is_mul, is_mulh, is_rem};
        negp_q <= sign1 ^ sign2;
        sign1_q <= sign1;
        cnt_q <= is_w ? 6'(MDU_ITER32 - 1) : 6'(MDU_ITER64 - 1);
        acc_q <= {64'b0, is_mul ? mag2 : is_w ? {mag1[31:0], 32'b0} : mag1};
        opb_q <= is_mul ? mag1 : mag2;
        if (special) res_q <= spec_res;
      end else if (state_q == MDU_CALC) begin
        acc_q <= acc_n;
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == '0) res_q <= fin_res;
      end
    end
  end
  assign bus.req_ready_o = state_q == MDU_IDLE;
  assign bus.resp_valid_o = state_q == MDU_DONE;
  assign bus.busy_o = state_q == MDU_CALC || state_q == MDU_DONE;
  assign bus.mdu_res_o = res_q;
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors with hand-computed results, latencies and handshake checks for mdu_seq.
module tb_mdu_seq;
  import mdu_seq_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  mdu_seq_if bus ();
  mdu_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_state(input string tag, input logic [2:0] exp);
    chk(tag, 64'({bus.req_ready_o, bus.resp_valid_o, bus.busy_o}), 64'(exp));
  endtask
  task automatic issue(input int op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.req_valid_i = 1;
    bus.mdu_info_i = 13'(1) << op;
    bus.rs1_rdata_i = a;
    bus.rs2_rdata_i = b;
    @(posedge clk);
    #1;
    bus.req_valid_i = 0;
    bus.rs1_rdata_i = 64'h1234_5678_9ABC_DEF0;
    bus.rs2_rdata_i = 64'h0FED_CBA9_8765_4321;
  endtask
  task automatic wait_resp(input string tag, input int exp_lat);
    int lat = 1;
    bit bz = 1;
    while (!bus.resp_valid_o && lat < 100) begin
      if (!bus.busy_o) bz = 0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy"}, 64'(bz & bus.busy_o), 64'd1);
  endtask
  task automatic hs(input string tag);
    @(negedge clk);
    bus.resp_ready_i = 1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 0;
    chk_state({tag, ".idle"}, 3'b100);
  endtask
  task automatic run(input string tag, input int op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp, input int lat);
    issue(op, a, b);
    wait_resp(tag, lat);
    chk({tag, ".res"}, bus.mdu_res_o, exp);
    hs(tag);
  endtask
  initial begin
    logic [63:0] r0;
    bit stable;
    bit rose;
    bus.req_valid_i = 0;
    bus.mdu_info_i = '0;
    bus.rs1_rdata_i = '0;
    bus.rs2_rdata_i = '0;
    bus.flush_i = 0;
    bus.resp_ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset.state", 3'b100);
    chk("reset.res", bus.mdu_res_o, 64'd0);
    @(negedge clk);
    rst = 0;
    run("mul", MDU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run("mulhu", MDU_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("mulh", MDU_MULH, '1, '1, 64'd0, 65);
    run("mulhsu", MDU_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("mulw", MDU_MULW, 64'hAAAA_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run("div0", MDU_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("remu0", MDU_REMU, 64'd5, 64'd0, 64'd5, 1);
    run("divw0", MDU_DIVW, 64'h1_0000_0005, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("div_ovf", MDU_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("rem_ovf", MDU_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run("divw_ovf", MDU_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run("div_neg", MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_neg", MDU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("divu", MDU_DIVU, 64'd100, 64'd7, 64'd14, 65);
    run("divuw", MDU_DIVUW, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run("remuw", MDU_REMUW, 64'd10, 64'd3, 64'd1, 33);
    run("remw_neg", MDU_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    issue(MDU_DIV, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1;
    @(posedge clk);
    #1;
    bus.flush_i = 0;
    chk_state("flush.state", 3'b100);
    rose = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid_o) rose = 1;
    end
    chk("flush.novalid", 64'(rose), 64'd0);
    @(negedge clk);
    bus.req_valid_i = 1;
    bus.flush_i = 1;
    bus.mdu_info_i = 13'(1) << MDU_DIV;
    bus.rs1_rdata_i = 64'd5;
    bus.rs2_rdata_i = 64'd0;
    @(posedge clk);
    #1;
    bus.req_valid_i = 0;
    bus.flush_i = 0;
    chk_state("flush_acc.state", 3'b100);
    @(posedge clk);
    #1;
    chk_state("flush_acc.still", 3'b100);
    issue(MDU_REMUW, 64'd10, 64'd3);
    wait_resp("hold", 33);
    r0 = bus.mdu_res_o;
    chk("hold.res", r0, 64'd1);
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      bus.req_valid_i = 1;
      bus.mdu_info_i = 13'(1) << MDU_DIV;
      bus.rs1_rdata_i = 64'd5;
      bus.rs2_rdata_i = 64'd0;
      @(posedge clk);
      #1;
      if (bus.mdu_res_o !== r0 || !bus.resp_valid_o) stable = 0;
    end
    bus.req_valid_i = 0;
    chk("hold.stable", 64'(stable), 64'd1);
    hs("hold");
    @(posedge clk);
    #1;
    chk_state("hold.noaccept", 3'b100);
    issue(MDU_MUL, 64'd7, 64'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk_state("rst_mid.state", 3'b100);
    chk("rst_mid.res", bus.mdu_res_o, 64'd0);
    run("after_rst", MDU_MUL, 64'd7, 64'd3, 64'd21, 65);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
